// File: rtl/div_defs.sv
// Shared definitions for the sequential signed divider: FSM state encodings
// and default widths.
package div_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DIV_N = 32;
  localparam int DIV_M = 16;
  localparam int CNT_W = $clog2(DIV_N);

endpackage

// File: rtl/abs_sign.sv
// Splits a two's complement value into its unsigned magnitude and sign bit.
// The most negative value maps to 2^(W-1), which still fits W unsigned bits.
module abs_sign #(
  parameter int W = 16
) (
  input  logic [W-1:0] val,
  output logic [W-1:0] mag,
  output logic         sign
);

  assign sign = val[W-1];
  assign mag  = sign ? ((~val) + W'(1)) : val;

endmodule

// File: rtl/divider2.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, one
// quotient bit per clock, sign correction in a final cycle.
//
// state | meaning
// IDLE  | waiting for start, ready high
// CALC  | one quotient bit per edge, N edges
// SIGN  | apply signs, register results
// DONE  | done pulse, accepts a new start like IDLE
module divider2
  import div_defs::*;
#(
  parameter int N = DIV_N,
  parameter int m = DIV_M
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] dividend,
  input  logic signed [m-1:0] divisor,
  output logic                ready,
  output logic                done,
  output logic signed [N-1:0] quotient,
  output logic signed [m-1:0] remainder,
  output logic                div_zero,
  output logic                ovf
);

  localparam int CW = $clog2(N);

  logic [N-1:0] a_mag;
  logic         a_sign;
  logic [m-1:0] b_mag;
  logic         b_sign;

  abs_sign #(.W(N)) u_abs_dividend (.val(dividend), .mag(a_mag), .sign(a_sign));
  abs_sign #(.W(m)) u_abs_divisor  (.val(divisor),  .mag(b_mag), .sign(b_sign));

  state_t       state;
  logic [N-1:0] q_reg;     // dividend magnitude shifting out, quotient bits shifting in
  logic [m-1:0] d_reg;     // divisor magnitude
  logic [m:0]   part;      // partial remainder, one guard bit above the divisor width
  logic         neg_q;
  logic         neg_r;
  logic         ovf_pend;
  logic [CW-1:0] cnt;

  logic [m:0] shifted;
  logic [m:0] diff;
  logic       fits;
  logic       ovf_cond;

  // Trial subtraction for the current quotient bit.
  always_comb begin
    shifted = {part[m-1:0], q_reg[N-1]};
    diff    = shifted - {1'b0, d_reg};
    fits    = (shifted >= {1'b0, d_reg});
  end

  assign ovf_cond = (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == {m{1'b1}});

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      part      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf_pend  <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          if (start) begin
            if (divisor == '0) begin
              // Divide by zero skips the iteration and reports immediately.
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '0;
              remainder <= '0;
              div_zero  <= 1'b1;
              ovf       <= 1'b0;
            end else begin
              state    <= CALC;
              ready    <= 1'b0;
              q_reg    <= a_mag;
              d_reg    <= b_mag;
              part     <= '0;
              neg_q    <= a_sign ^ b_sign;
              neg_r    <= a_sign;
              ovf_pend <= ovf_cond;
              cnt      <= CW'(N - 1);
            end
          end
        end
        CALC: begin
          q_reg <= {q_reg[N-2:0], fits};
          part  <= fits ? diff : shifted;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) state <= SIGN;
        end
        SIGN: begin
          // Remainder magnitude is below 2^(m-1), so the top partial bit is always zero here.
          quotient  <= neg_q ? -q_reg : q_reg;
          remainder <= neg_r ? -part[m-1:0] : part[m-1:0];
          ovf       <= ovf_pend;
          div_zero  <= 1'b0;
          done      <= 1'b1;
          ready     <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider2.sv
// Scoreboard bench for divider2: the driver pushes hand-computed results,
// a monitor pops and compares on every done pulse.
module tb_divider2;

  localparam int N = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [31:0] dividend;
  logic signed [15:0] divisor;
  logic               ready;
  logic               done;
  logic signed [31:0] quotient;
  logic signed [15:0] remainder;
  logic               div_zero;
  logic               ovf;

  divider2 #(.N(32), .m(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic signed [31:0] q;
    logic signed [15:0] r;
    logic               dz;
    logic               ov;
    int                 done_edge;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   done_cnt = 0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no done", edge_cnt);
      end else begin
        e = sb.pop_front();
        chk({e.name, " quotient"},  quotient,  e.q);
        chk({e.name, " remainder"}, remainder, e.r);
        chk({e.name, " div_zero"},  div_zero,  e.dz);
        chk({e.name, " ovf"},       ovf,       e.ov);
        chk({e.name, " done_edge"}, edge_cnt,  e.done_edge);
        chk({e.name, " ready"},     ready,     1'b1);
      end
    end
  end

  // Issue one operation at posedge+1 and record its expected result.
  task automatic issue(input string nm, input int a, input int b,
                       input int eq, input int er, input logic edz, input logic eov);
    exp_t e;
    int   n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!ready) begin
      chk({nm, " ready_wait"}, ready, 1'b1);
      return;
    end
    dividend = a;
    divisor  = 16'(b);
    start    = 1'b1;
    e.name      = nm;
    e.q         = eq;
    e.r         = 16'(er);
    e.dz        = edz;
    e.ov        = eov;
    e.done_edge = edge_cnt + 1 + (edz ? 0 : N + 1);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " ready_after_accept"}, ready, edz);
  endtask

  // Wait (bounded) until the cycle in which done is high.
  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!done) chk({nm, " done_timeout"}, done, 1'b1);
  endtask

  int a_acc;
  int dcount;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready",     ready,     1'b1);
    chk("reset done",      done,      1'b0);
    chk("reset quotient",  quotient,  32'sd0);
    chk("reset remainder", remainder, 16'sd0);
    chk("reset div_zero",  div_zero,  1'b0);
    chk("reset ovf",       ovf,       1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue("p_div", 1000, 7, 142, 6, 1'b0, 1'b0);        wait_done("p_div");
    issue("n_dvd", -1000, 7, -142, -6, 1'b0, 1'b0);     wait_done("n_dvd");
    issue("n_dvs", 1000, -7, -142, 6, 1'b0, 1'b0);      wait_done("n_dvs");
    issue("n_both", -1000, -7, 142, -6, 1'b0, 1'b0);    wait_done("n_both");
    issue("roundtrip", -3962745, 321, -12345, 0, 1'b0, 1'b0); wait_done("roundtrip");
    issue("min_by_min16", 32'sh80000000, -32768, 65536, 0, 1'b0, 1'b0); wait_done("min_by_min16");
    issue("ovf_case", 32'sh80000000, -1, 32'sh80000000, 0, 1'b0, 1'b1); wait_done("ovf_case");
    issue("div_zero", 55, 0, 0, 0, 1'b1, 1'b0);         wait_done("div_zero");
    issue("after_dz", 9, 3, 3, 0, 1'b0, 1'b0);          wait_done("after_dz");

    // Start pulsed mid-divide must be ignored.
    issue("busy_div", 1000, 7, 142, 6, 1'b0, 1'b0);
    a_acc = edge_cnt;
    while (edge_cnt < a_acc + 9) begin
      @(posedge clk); #1;
    end
    dividend = 100;
    divisor  = 16'sd9;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    wait_done("busy_div");
    issue("in_done", 100, 9, 11, 1, 1'b0, 1'b0);        wait_done("in_done");

    // Reset in the middle of a divide: no expectation is pushed for it.
    dividend = 1000;
    divisor  = 16'sd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    a_acc    = edge_cnt;
    while (edge_cnt < a_acc + 14) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset ready",     ready,     1'b1);
    chk("midreset done",      done,      1'b0);
    chk("midreset quotient",  quotient,  32'sd0);
    chk("midreset remainder", remainder, 16'sd0);
    chk("midreset div_zero",  div_zero,  1'b0);
    chk("midreset ovf",       ovf,       1'b0);
    rst_n  = 1'b1;
    dcount = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, dcount);

    issue("post_reset", 7, 1000, 0, 7, 1'b0, 1'b0);     wait_done("post_reset");
    @(posedge clk); #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider2.md
Name: divider2

Overview:
- Sequential signed divider; the inverse of the FIR datapath multiplier (res = a*b). Recovers a factor from an N-bit product and an m-bit operand.
- Restoring shift-subtract on magnitudes, one quotient bit per clock, sign-corrected at the end.
- Used for FIR gain normalisation and coefficient checks, where a single-cycle divider is not affordable.

Parameters:
- N, 32, dividend and quotient width (signed, two's complement)
- m, 16, divisor and remainder width (signed, two's complement)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; accepted only when ready=1
- dividend  input  N  signed dividend, sampled on the accepting edge
- divisor  input  m  signed divisor, sampled on the accepting edge
- ready  output  1  high in IDLE and DONE only
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  N  signed quotient, truncated toward zero
- remainder  output  m  signed remainder; sign follows the dividend
- div_zero  output  1  divisor was 0
- ovf  output  1  quotient not representable (-2^(N-1) / -1)

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE; ready = 1.
  - done, div_zero, ovf, quotient and remainder = 0.
  - Reset mid-operation aborts the divide; no done is ever produced for it.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - start=1 with divisor≠0 -> CALC on the next edge.
  - On that edge: latch |dividend| (N-bit unsigned), |divisor| (m-bit unsigned), the operand signs, and the ovf condition. Clear the partial remainder (m+1 bits). Bit counter = N-1.
  - start=1 with divisor=0 -> DONE directly on that edge. quotient=0, remainder=0, div_zero=1, ovf=0.
- CALC, once per edge, N edges total:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - If partial ≥ |divisor|: subtract, and shift in quotient bit 1; otherwise shift in 0.
  - Decrement counter; at counter 0 -> SIGN.
- SIGN, one edge, then -> DONE:
  - quotient = negate(magnitude) if the dividend and divisor signs differ.
  - remainder = negate(partial) if the dividend is negative.
  - Register ovf and clear div_zero.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE.
  - DONE accepts start like IDLE, so back-to-back operation is possible.
- Latency:
  - Start accepted at edge 0 -> done high in the cycle after edge N+1 (N+2 clocks start-to-start).
  - Divide-by-zero: done high in the cycle after edge 0.
- start while CALC/SIGN: ignored; the operands in flight are unaffected.
- Outputs hold their last result until the next SIGN/DONE update. They do not return to 0 between operations.
- Width rules:
  - |divisor| ≤ 2^(m-1), so |remainder| < 2^(m-1) and always fits m bits signed.
  - -2^(N-1) / -1 gives quotient -2^(N-1) (wrapped), remainder 0, ovf=1.
  - All other non-zero-divisor cases: ovf=0.
- No combinational path from any input to any output.

Decomposition:
- Shared include/package div_defs: state encodings (IDLE=2'd0, CALC=2'd1, SIGN=2'd2, DONE=2'd3) and the counter width constant $clog2(N).
- One sub-module: abs_sign (parameter W). Outputs the W-bit unsigned magnitude and sign bit of a signed input.
  - Instantiated twice: once for the dividend, once for the divisor.
  - Its negate logic is reused in SIGN.

Test Plan:
- dividend=1000, divisor=7, start at edge 0 -> done high after edge 33 (N=32); quotient=142, remainder=6, ovf=0, div_zero=0; ready low edges 1..33.
- Sign combinations, with the same latency each time:
  - -1000/7 -> q=-142, r=-6.
  - 1000/-7 -> q=-142, r=6.
  - -1000/-7 -> q=142, r=-6.
- Round trip with multiplier2: dividend=-3962745 (=-12345*321), divisor=321 -> q=-12345, r=0. Extremes:
  - dividend=-2147483648, divisor=-32768 -> q=65536, r=0.
  - dividend=-2147483648, divisor=-1 -> q=-2147483648, r=0, ovf=1.
- divisor=0, dividend=55 -> done the cycle after edge 0; div_zero=1, q=0, r=0. The next operation 9/3 -> q=3, r=0, div_zero=0.
- Second start (100/9) pulsed at edge 10 during a 1000/7 divide -> ignored; the result is still 142 r 6, and only one done occurs. Then start in the DONE cycle -> accepted; 11 r 1 after N+1 more edges.
- rst_n low at edge 15 of a divide -> all outputs 0 and ready=1 after that edge; no done appears within 40 further cycles unless start is issued.
